fb_pattern_writer: RTL and testbench

FB_PATTERN_WRITER -- requirements
Module: fb_pattern_writer

---
 rtl/fb_pattern_writer_pkg.sv | 19 +
 rtl/fb_pattern_pixel.sv | 39 +++
 rtl/fb_pattern_writer.sv | 118 +++++++++++
 tb/tb_fb_pattern_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pattern_writer_pkg.sv
// Shared definitions for the framebuffer pattern writer: FSM state encoding,
// pattern mode codes and a small byte-building helper.
package fb_pattern_writer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_XOR   = 2'd1;
    localparam logic [1:0] MODE_GRAD  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    function automatic logic [7:0] nibble_pair(input logic [3:0] n);
        return {n, n};
    endfunction

endpackage

// File: rtl/fb_pattern_pixel.sv
// Combinational pattern generator: maps (mode, colour, x, y) to one pixel word.
module fb_pattern_pixel
    import fb_pattern_writer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] color,
    input  logic [7:0]        x,
    input  logic [3:0]        y,
    output logic [DATA_W-1:0] pixel
);

    logic [7:0]        xor_byte;
    logic [DATA_W-1:0] xor_word;
    logic [DATA_W-1:0] grad_word;

    assign xor_byte = nibble_pair(x[3:0] ^ y[3:0]);

    // Replicate the byte pattern bit-wise so any pixel width gets every byte lane filled.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_lane
            assign xor_word[gi]  = xor_byte[gi % 8];
            assign grad_word[gi] = x[gi % 8];
        end
    endgenerate

    always_comb begin
        pixel = color;
        case (mode)
            MODE_SOLID: pixel = color;
            MODE_XOR:   pixel = xor_word;
            MODE_GRAD:  pixel = grad_word;
            MODE_CHECK: pixel = (x[3] ^ y[3]) ? ~color : color;
        endcase
    end

endmodule

// File: rtl/fb_pattern_writer.sv
// Fills an H_RES x V_RES frame with a test pattern, one handshaked write per pixel,
// with optional idle cycles between writes.
module fb_pattern_writer
    import fb_pattern_writer_pkg::*;
#(
    parameter int H_RES  = 320,
    parameter int V_RES  = 200,
    parameter int PITCH  = 320,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 8,
    parameter int GAP    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] color,
    input  logic [ADDR_W-1:0] base,
    input  logic              ready,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    output logic              busy,
    output logic              done
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

    logic [1:0]        state_reg;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic [ADDR_W-1:0] line_reg;
    logic [1:0]        mode_reg;
    logic [DATA_W-1:0] color_reg;
    logic [31:0]       gap_cnt_reg;

    logic last_x;
    logic last_y;

    assign last_x = (x_reg == XW'(H_RES - 1));
    assign last_y = (y_reg == YW'(V_RES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            line_reg    <= '0;
            mode_reg    <= '0;
            color_reg   <= '0;
            gap_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mode_reg  <= mode;
                        color_reg <= color;
                        line_reg  <= base;
                        x_reg     <= '0;
                        y_reg     <= '0;
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Abort wins over an acceptance in the same cycle; that write still went out.
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (ready) begin
                        if (last_x && last_y) begin
                            state_reg <= ST_FINISH;
                        end else begin
                            if (last_x) begin
                                x_reg    <= '0;
                                y_reg    <= y_reg + YW'(1);
                                line_reg <= line_reg + ADDR_W'(PITCH);
                            end else begin
                                x_reg <= x_reg + XW'(1);
                            end
                            gap_cnt_reg <= '0;
                            state_reg   <= (GAP > 0) ? ST_GAP : ST_WRITE;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (gap_cnt_reg == 32'(GAP - 1)) begin
                        state_reg <= ST_WRITE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Address and data derive only from registers, so they stay put while ready is low.
    assign o_address = line_reg + ADDR_W'(x_reg);
    assign o_we      = (state_reg == ST_WRITE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FINISH);

    fb_pattern_pixel #(
        .DATA_W (DATA_W)
    ) u_pixel (
        .mode  (mode_reg),
        .color (color_reg),
        .x     (8'(x_reg)),
        .y     (4'(y_reg)),
        .pixel (o_data)
    );

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer on a 4x2 frame with pitch 8 (GAP 0 and GAP 2 instances).
module tb_fb_pattern_writer;

    localparam int AW = 26;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset, start, abort, ready;
    logic [1:0]    mode;
    logic [DW-1:0] color;
    logic [AW-1:0] base;

    logic [AW-1:0] addr0, addr2;
    logic [DW-1:0] data0, data2;
    logic          we0, we2, busy0, busy2, done0, done2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fb_pattern_writer #(.H_RES(4), .V_RES(2), .PITCH(8), .ADDR_W(AW), .DATA_W(DW), .GAP(0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode), .color(color),
        .base(base), .ready(ready), .o_address(addr0), .o_data(data0), .o_we(we0),
        .busy(busy0), .done(done0));

    fb_pattern_writer #(.H_RES(4), .V_RES(2), .PITCH(8), .ADDR_W(AW), .DATA_W(DW), .GAP(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .mode(mode), .color(color),
        .base(base), .ready(ready), .o_address(addr2), .o_data(data2), .o_we(we2),
        .busy(busy2), .done(done2));

    typedef struct packed {
        logic [1:0]          mode;
        logic [7:0]          color;
        logic [AW-1:0]       base;
        logic                toggle;
        logic [0:7][AW-1:0]  exp_addr;
        logic [0:7][7:0]     exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_fill(input vec_t v, input string tag);
        logic [AW-1:0] got_addr[$];
        logic [7:0]    got_data[$];
        int            dones = 0;
        bit            held, prev_acc, finished = 0;
        logic [AW-1:0] h_addr;
        logic [7:0]    h_data;
        mode = v.mode; color = v.color; base = v.base; ready = 1'b1; start = 1'b1;
        step();
        check({tag, "_we_after_start"}, 32'(we0), 32'd1);
        // Scramble the inputs: a fill in progress must ignore them.
        start = 1'b0; mode = ~v.mode; color = ~v.color; base = 26'h155;
        for (int cyc = 0; cyc < 60 && !finished; cyc++) begin
            ready    = v.toggle ? (cyc % 2 == 0) : 1'b1;
            start    = (cyc == 3);
            held     = we0 && !ready;
            h_addr   = addr0;
            h_data   = data0;
            prev_acc = we0 && ready;
            if (prev_acc) begin
                got_addr.push_back(addr0);
                got_data.push_back(data0);
            end
            step();
            if (held) begin
                check({tag, "_hold_addr"}, 32'(addr0), 32'(h_addr));
                check({tag, "_hold_data"}, 32'(data0), 32'(h_data));
                check({tag, "_hold_we"}, 32'(we0), 32'd1);
            end
            if (done0) begin
                dones++;
                check({tag, "_done_timing"}, 32'(prev_acc && got_addr.size() == 8), 32'd1);
            end
            if (!busy0) finished = 1;
        end
        start = 1'b0;
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_write_count"}, 32'(got_addr.size()), 32'd8);
        check({tag, "_done_count"}, 32'(dones), 32'd1);
        check({tag, "_busy_after"}, 32'(busy0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  (i < got_addr.size()) ? 32'(got_addr[i]) : 32'hFFFF_FFFF, 32'(v.exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i),
                  (i < got_data.size()) ? 32'(got_data[i]) : 32'hFFFF_FFFF, 32'(v.exp_data[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int            acc;
        bit            aborted;
        int            extra_we, extra_done;
        logic [7:0]    gap_data[$];

        vecs[0] = '{mode: 2'd0, color: 8'h29, base: 26'd100, toggle: 1'b0,
                    exp_addr: {26'd100, 26'd101, 26'd102, 26'd103, 26'd108, 26'd109, 26'd110, 26'd111},
                    exp_data: {8{8'h29}}};
        vecs[1] = '{mode: 2'd1, color: 8'h00, base: 26'd0, toggle: 1'b1,
                    exp_addr: {26'd0, 26'd1, 26'd2, 26'd3, 26'd8, 26'd9, 26'd10, 26'd11},
                    exp_data: {8'h00, 8'h11, 8'h22, 8'h33, 8'h11, 8'h00, 8'h33, 8'h22}};
        vecs[2] = '{mode: 2'd2, color: 8'hFF, base: 26'd20, toggle: 1'b0,
                    exp_addr: {26'd20, 26'd21, 26'd22, 26'd23, 26'd28, 26'd29, 26'd30, 26'd31},
                    exp_data: {8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03}};
        vecs[3] = '{mode: 2'd3, color: 8'h0F, base: 26'd40, toggle: 1'b0,
                    exp_addr: {26'd40, 26'd41, 26'd42, 26'd43, 26'd48, 26'd49, 26'd50, 26'd51},
                    exp_data: {8{8'h0F}}};
        vecs[4] = '{mode: 2'd0, color: 8'hA5, base: 26'h3FF_FFFE, toggle: 1'b0,
                    exp_addr: {26'h3FF_FFFE, 26'h3FF_FFFF, 26'd0, 26'd1, 26'd6, 26'd7, 26'd8, 26'd9},
                    exp_data: {8{8'hA5}}};

        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b0;
        mode = 2'd0; color = 8'h00; base = '0;
        step();
        step();
        check("reset_we", 32'(we0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_done", 32'(done0), 32'd0);
        check("reset_addr", 32'(addr0), 32'd0);
        check("reset_data", 32'(data0), 32'd0);
        check("reset_busy_gap", 32'(busy2), 32'd0);

        // Start is presented on the very first cycle after reset release.
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_fill(vecs[i], $sformatf("vec%0d", i));
            $display("vector %0d done: mode=%0d base=%0h", i, vecs[i].mode, vecs[i].base);
        end

        // Abort on the third accepted write.
        step();
        mode = 2'd0; color = 8'h3C; base = 26'd50; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        acc = 0; aborted = 0;
        for (int cyc = 0; cyc < 20 && !aborted; cyc++) begin
            if (we0 && ready) begin
                acc++;
                if (acc == 3) abort = 1'b1;
            end
            step();
            if (abort) begin
                aborted = 1;
                abort   = 1'b0;
                check("abort_we", 32'(we0), 32'd0);
                check("abort_busy", 32'(busy0), 32'd0);
                check("abort_done", 32'(done0), 32'd0);
            end
        end
        check("abort_seen", 32'(aborted), 32'd1);
        extra_we = 0; extra_done = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (we0) extra_we++;
            if (done0) extra_done++;
            step();
        end
        check("abort_total_writes", 32'(acc + extra_we), 32'd3);
        check("abort_no_done", 32'(extra_done), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_addr", 32'(addr0), 32'd50);
        check("restart_data", 32'(data0), 32'h3C);
        check("restart_we", 32'(we0), 32'd1);
        for (int cyc = 0; cyc < 30 && busy0; cyc++) step();
        check("restart_idle", 32'(busy0), 32'd0);
        $display("abort sequence done: writes before abort=%0d", acc);

        // GAP=2 instance: write, two idle cycles, repeat.
        reset = 1'b1;
        step();
        reset = 1'b0; mode = 2'd2; color = 8'h00; base = '0; ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            check($sformatf("gap_we_%0d", cyc), 32'(we2), 32'((cyc % 3) == 0));
            if (we2) gap_data.push_back(data2);
            step();
        end
        check("gap_done", 32'(done2), 32'd1);
        check("gap_count", 32'(gap_data.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("gap_data%0d", i),
                  (i < gap_data.size()) ? 32'(gap_data[i]) : 32'hFFFF_FFFF, 32'(i % 4));
        end
        step();
        $display("gap sequence done: writes=%0d", gap_data.size());

        // Reset in the middle of a fill, with start held high.
        mode = 2'd1; color = 8'h55; base = 26'd1234; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1; start = 1'b1;
        step();
        check("midreset_we", 32'(we0), 32'd0);
        check("midreset_busy", 32'(busy0), 32'd0);
        check("midreset_done", 32'(done0), 32'd0);
        check("midreset_addr", 32'(addr0), 32'd0);
        check("midreset_data", 32'(data0), 32'd0);
        step();
        check("midreset_start_ignored", 32'(busy0), 32'd0);
        reset = 1'b0; start = 1'b0;
        step();
        check("postreset_idle", 32'(busy0), 32'd0);
        $display("mid-fill reset sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
